// File: rtl/audio_out_sched_pkg.sv
// Shared types and constants for the stereo audio output scheduler.
package audio_out_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_FETCH,
    ST_CAPTURE,
    ST_PRESENT
  } state_e;

  localparam int unsigned TICK_DIV_DEFAULT = 2083;

  // Underrun behaviour selectors for HOLD_ON_UNDERRUN.
  localparam bit UNDERRUN_ZERO = 1'b0;
  localparam bit UNDERRUN_HOLD = 1'b1;

endpackage

// File: rtl/audio_out_sched_tick.sv
// Sample-rate divider: one-cycle tick every TICK_DIV clocks while enabled.
module sample_tick_gen
  import audio_out_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int unsigned        CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0]      LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (!enable)              count_d = '0;
    else if (count_q == LAST) count_d = '0;
    else                      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign tick = enable && (count_q == LAST);

endmodule

// File: rtl/audio_out_sched.sv
// Drains left/right FIFOs in lockstep at the audio tick rate and presents
// each stereo pair over valid/ready, counting underruns and missed ticks.
module audio_out_sched
  import audio_out_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned TICK_DIV         = TICK_DIV_DEFAULT,
  parameter bit          HOLD_ON_UNDERRUN = UNDERRUN_ZERO,
  parameter int unsigned CNT_WIDTH        = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] left_dout,
  input  logic                  left_empty,
  output logic                  left_rd_en,
  input  logic [DATA_WIDTH-1:0] right_dout,
  input  logic                  right_empty,
  output logic                  right_rd_en,
  output logic [DATA_WIDTH-1:0] left_audio,
  output logic [DATA_WIDTH-1:0] right_audio,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  underrun_count,
  output logic [CNT_WIDTH-1:0]  missed_tick_count
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] left_q, left_d, right_q, right_d;
  logic [CNT_WIDTH-1:0]  urun_q, urun_d, miss_q, miss_d;
  logic                  tick;
  logic                  underrun_entry;

  sample_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .tick   (tick)
  );

  // One FIFO alone non-empty is still an underrun: reading neither keeps L/R aligned.
  assign underrun_entry = (state_q == ST_WAIT) && enable && tick &&
                          (left_empty || right_empty);

  always_comb begin
    state_d = state_q;
    left_d  = left_q;
    right_d = right_q;
    urun_d  = urun_q;
    miss_d  = miss_q;
    case (state_q)
      ST_IDLE:    if (enable) state_d = ST_WAIT;
      ST_WAIT: begin
        if (!enable)                         state_d = ST_IDLE;
        else if (tick && !left_empty && !right_empty) state_d = ST_FETCH;
        else if (tick)                       state_d = ST_PRESENT;
      end
      ST_FETCH:   state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        left_d  = left_dout;
        right_d = right_dout;
        state_d = ST_PRESENT;
      end
      ST_PRESENT: if (out_ready) state_d = enable ? ST_WAIT : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    // In hold mode the output registers already carry the last captured pair.
    if (underrun_entry && (HOLD_ON_UNDERRUN == UNDERRUN_ZERO)) begin
      left_d  = '0;
      right_d = '0;
    end
    if (underrun_entry && (urun_q != '1)) urun_d = urun_q + 1'b1;
    if ((state_q == ST_PRESENT) && tick && (miss_q != '1)) miss_d = miss_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      left_q  <= '0;
      right_q <= '0;
      urun_q  <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      left_q  <= left_d;
      right_q <= right_d;
      urun_q  <= urun_d;
      miss_q  <= miss_d;
    end
  end

  assign left_rd_en        = (state_q == ST_FETCH);
  assign right_rd_en       = (state_q == ST_FETCH);
  assign out_valid         = (state_q == ST_PRESENT);
  assign left_audio        = left_q;
  assign right_audio       = right_q;
  assign underrun_count    = urun_q;
  assign missed_tick_count = miss_q;

endmodule

// File: tb/tb_audio_out_sched.sv
// Directed self-checking bench for audio_out_sched with TICK_DIV=8.
module tb_audio_out_sched;

  logic        clock = 1'b0;
  logic        reset, enable, en1, out_ready;
  logic [31:0] left_dout = '0, right_dout = '0;
  logic        left_empty, right_empty, left_rd_en, right_rd_en;
  logic [31:0] left_audio, right_audio;
  logic        out_valid;
  logic [15:0] ucnt, mcnt;

  logic [31:0] l1_dout, r1_dout, l1_audio, r1_audio;
  logic        l1_empty, r1_empty, l1_rd, r1_rd, valid1;
  logic [15:0] ucnt1, mcnt1;

  logic [31:0] lmem [16];
  logic [31:0] rmem [16];
  int unsigned lwr = 0, rwr = 0, lrd = 0, rrd = 0;
  int unsigned nl = 0, nr = 0, nsplit = 0;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  audio_out_sched #(.DATA_WIDTH(32), .TICK_DIV(8), .HOLD_ON_UNDERRUN(1'b0), .CNT_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .left_dout(left_dout), .left_empty(left_empty), .left_rd_en(left_rd_en),
    .right_dout(right_dout), .right_empty(right_empty), .right_rd_en(right_rd_en),
    .left_audio(left_audio), .right_audio(right_audio),
    .out_valid(out_valid), .out_ready(out_ready),
    .underrun_count(ucnt), .missed_tick_count(mcnt)
  );

  audio_out_sched #(.DATA_WIDTH(32), .TICK_DIV(8), .HOLD_ON_UNDERRUN(1'b1), .CNT_WIDTH(16)) dut_hold (
    .clock(clock), .reset(reset), .enable(en1),
    .left_dout(l1_dout), .left_empty(l1_empty), .left_rd_en(l1_rd),
    .right_dout(r1_dout), .right_empty(r1_empty), .right_rd_en(r1_rd),
    .left_audio(l1_audio), .right_audio(r1_audio),
    .out_valid(valid1), .out_ready(out_ready),
    .underrun_count(ucnt1), .missed_tick_count(mcnt1)
  );

  // FIFO models: data appears one cycle after the read strobe.
  assign left_empty  = (lrd == lwr);
  assign right_empty = (rrd == rwr);

  always @(posedge clock) begin
    if (left_rd_en && (lrd != lwr)) begin
      left_dout <= lmem[lrd[3:0]];
      lrd       <= lrd + 1;
    end
    if (right_rd_en && (rrd != rwr)) begin
      right_dout <= rmem[rrd[3:0]];
      rrd        <= rrd + 1;
    end
    if (left_rd_en)                nl     <= nl + 1;
    if (right_rd_en)               nr     <= nr + 1;
    if (left_rd_en != right_rd_en) nsplit <= nsplit + 1;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [31:0] l, input logic [31:0] r);
    lmem[lwr[3:0]] = l;
    lwr++;
    rmem[rwr[3:0]] = r;
    rwr++;
  endtask

  task automatic do_reset();
    step();
    reset  = 1'b1;
    enable = 1'b0;
    en1    = 1'b0;
    step();
    step();
    reset = 1'b0;
    lwr   = lrd;
    rwr   = rrd;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (left_rd_en !== 1'b0 || right_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b/%b want 0/0", left_rd_en, right_rd_en); end
    checks++; if (left_audio !== 32'h0 || right_audio !== 32'h0) begin errors++; $display("FAIL reset_audio: got %h/%h want 0/0", left_audio, right_audio); end
    checks++; if (ucnt !== 16'h0 || mcnt !== 16'h0) begin errors++; $display("FAIL reset_counters: got u=%0d m=%0d want 0/0", ucnt, mcnt); end
    checks++; if (valid1 !== 1'b0 || l1_audio !== 32'h0) begin errors++; $display("FAIL reset_hold_dut: got v=%b L=%h want 0/0", valid1, l1_audio); end
  endtask

  task automatic test_normal();
    int unsigned s_nl, s_nr, s_sp;
    int npairs, nrd;
    logic [31:0] el, er;
    do_reset();
    push(32'h10, 32'h20); push(32'h11, 32'h21); push(32'h12, 32'h22);
    out_ready = 1'b1;
    s_nl = nl; s_nr = nr; s_sp = nsplit; npairs = 0; nrd = 0;
    enable = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      step();
      if (left_rd_en) begin
        checks++;
        if (k != 8 + 8 * nrd) begin errors++; $display("FAIL normal_rd%0d_cycle: got %0d want %0d", nrd, k, 8 + 8 * nrd); end
        nrd++;
      end
      if (out_valid) begin
        el = 32'h10 + 32'(npairs);
        er = 32'h20 + 32'(npairs);
        checks++;
        if (k != 10 + 8 * npairs || left_audio !== el || right_audio !== er) begin
          errors++;
          $display("FAIL normal_pair%0d: got cycle=%0d L=%h R=%h want cycle=%0d L=%h R=%h",
                   npairs, k, left_audio, right_audio, 10 + 8 * npairs, el, er);
        end
        npairs++;
      end
      if (k == 30) enable = 1'b0;
    end
    checks++; if (npairs != 3) begin errors++; $display("FAIL normal_pair_count: got %0d want 3", npairs); end
    checks++; if (nl - s_nl != 3 || nr - s_nr != 3) begin errors++; $display("FAIL normal_strobes: got %0d/%0d want 3/3", nl - s_nl, nr - s_nr); end
    checks++; if (nsplit != s_sp) begin errors++; $display("FAIL normal_split_strobe: got %0d want 0", nsplit - s_sp); end
    checks++; if (ucnt !== 16'd0 || mcnt !== 16'd0) begin errors++; $display("FAIL normal_counters: got u=%0d m=%0d want 0/0", ucnt, mcnt); end
  endtask

  task automatic test_underrun();
    int unsigned s_nl, s_nr;
    int nv;
    do_reset();
    push(32'h44, 32'h55);
    lmem[lwr[3:0]] = 32'h33;
    lwr++;
    out_ready = 1'b1;
    s_nl = nl; s_nr = nr; nv = 0;
    enable = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      step();
      if (out_valid) begin
        checks++;
        if (nv == 0 && (k != 10 || left_audio !== 32'h44 || right_audio !== 32'h55 || ucnt !== 16'd0)) begin
          errors++; $display("FAIL underrun_first_pair: got cycle=%0d L=%h R=%h u=%0d want 10 44 55 0", k, left_audio, right_audio, ucnt);
        end else if (nv == 1 && (k != 16 || left_audio !== 32'h0 || right_audio !== 32'h0 || ucnt !== 16'd1)) begin
          errors++; $display("FAIL underrun_zero_pair: got cycle=%0d L=%h R=%h u=%0d want 16 0 0 1", k, left_audio, right_audio, ucnt);
        end else if (nv > 1) begin
          errors++; $display("FAIL underrun_extra_valid: got valid at cycle %0d want none", k);
        end
        nv++;
      end
      if (k == 16) enable = 1'b0;
    end
    checks++; if (nv != 2) begin errors++; $display("FAIL underrun_valid_count: got %0d want 2", nv); end
    checks++; if (nl - s_nl != 1 || nr - s_nr != 1) begin errors++; $display("FAIL underrun_strobes: got %0d/%0d want 1/1", nl - s_nl, nr - s_nr); end
    checks++; if (lwr - lrd != 1) begin errors++; $display("FAIL underrun_left_kept: got %0d want 1", lwr - lrd); end
    checks++; if (ucnt !== 16'd1 || mcnt !== 16'd0) begin errors++; $display("FAIL underrun_counters: got u=%0d m=%0d want 1/0", ucnt, mcnt); end
  endtask

  task automatic test_hold();
    int nv, nrd;
    do_reset();
    l1_dout = 32'h5; r1_dout = 32'h6; l1_empty = 1'b0; r1_empty = 1'b0;
    out_ready = 1'b1;
    nv = 0; nrd = 0;
    en1 = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      step();
      if (l1_rd || r1_rd) begin
        checks++;
        if (!(l1_rd && r1_rd) || k != 8) begin errors++; $display("FAIL hold_strobe: got L=%b R=%b cycle=%0d want 1/1 at 8", l1_rd, r1_rd, k); end
        nrd++;
        l1_empty = 1'b1; r1_empty = 1'b1;
      end
      if (k == 10) begin l1_dout = 32'hDEAD; r1_dout = 32'hBEEF; end
      if (valid1) begin
        checks++;
        if (nv == 0 && (k != 10 || l1_audio !== 32'h5 || r1_audio !== 32'h6 || ucnt1 !== 16'd0)) begin
          errors++; $display("FAIL hold_first_pair: got cycle=%0d L=%h R=%h u=%0d want 10 5 6 0", k, l1_audio, r1_audio, ucnt1);
        end else if (nv == 1 && (k != 16 || l1_audio !== 32'h5 || r1_audio !== 32'h6 || ucnt1 !== 16'd1)) begin
          errors++; $display("FAIL hold_repeat_pair: got cycle=%0d L=%h R=%h u=%0d want 16 5 6 1", k, l1_audio, r1_audio, ucnt1);
        end else if (nv > 1) begin
          errors++; $display("FAIL hold_extra_valid: got valid at cycle %0d want none", k);
        end
        nv++;
      end
      if (k == 16) en1 = 1'b0;
    end
    checks++; if (nv != 2 || nrd != 1) begin errors++; $display("FAIL hold_counts: got valid=%0d reads=%0d want 2/1", nv, nrd); end
    checks++; if (mcnt1 !== 16'd0) begin errors++; $display("FAIL hold_missed: got %0d want 0", mcnt1); end
  endtask

  task automatic test_backpressure();
    int unsigned s_nl;
    int bad, late;
    do_reset();
    push(32'h60, 32'h70);
    out_ready = 1'b0;
    s_nl = nl; bad = 0; late = 0;
    enable = 1'b1;
    for (int k = 1; k <= 44; k++) begin
      step();
      if (k >= 10 && k <= 31 && (out_valid !== 1'b1 || left_audio !== 32'h60 || right_audio !== 32'h70)) bad++;
      if (k == 30) begin
        checks++; if (mcnt !== 16'd2) begin errors++; $display("FAIL bp_missed_stalled: got %0d want 2", mcnt); end
      end
      if (k == 31) out_ready = 1'b1;
      if (k == 32) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_drop: got %b want 0", out_valid); end
        enable = 1'b0;
      end
      if (k == 33) begin
        checks++; if (mcnt !== 16'd3) begin errors++; $display("FAIL bp_missed_handshake_tick: got %0d want 3", mcnt); end
      end
      if (k > 32 && out_valid) late++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable cycles want 0", bad); end
    checks++; if (late != 0) begin errors++; $display("FAIL bp_idle_after: got %0d valid cycles want 0", late); end
    checks++; if (nl - s_nl != 1) begin errors++; $display("FAIL bp_reads: got %0d want 1", nl - s_nl); end
    checks++; if (ucnt !== 16'd0) begin errors++; $display("FAIL bp_underrun: got %0d want 0", ucnt); end
  endtask

  task automatic test_reset_capture();
    int unsigned s_nl;
    int nv;
    out_ready = 1'b1;
    push(32'h80, 32'h90); push(32'h81, 32'h91);
    s_nl = nl; nv = 0;
    checks++; if (mcnt !== 16'd3) begin errors++; $display("FAIL rc_pre_missed: got %0d want 3", mcnt); end
    enable = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k == 8) begin
        checks++; if (left_rd_en !== 1'b1) begin errors++; $display("FAIL rc_fetch: got %b want 1", left_rd_en); end
      end
    end
    reset = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0 || mcnt !== 16'd0 || ucnt !== 16'd0 || left_audio !== 32'h0) begin
      errors++; $display("FAIL rc_after_reset: got v=%b m=%0d u=%0d L=%h want 0 0 0 0", out_valid, mcnt, ucnt, left_audio);
    end
    reset = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (out_valid) begin
        checks++;
        if (nv != 0 || k != 10 || left_audio !== 32'h81 || right_audio !== 32'h91) begin
          errors++; $display("FAIL rc_resume_pair: got n=%0d cycle=%0d L=%h R=%h want 0 10 81 91", nv, k, left_audio, right_audio);
        end
        nv++;
      end
      if (k == 10) enable = 1'b0;
    end
    checks++; if (nv != 1 || nl - s_nl != 2) begin errors++; $display("FAIL rc_counts: got valid=%0d reads=%0d want 1/2", nv, nl - s_nl); end
  endtask

  task automatic test_enable_present();
    int unsigned s_nl;
    int extra;
    do_reset();
    push(32'hA0, 32'hB0);
    out_ready = 1'b0;
    s_nl = nl; extra = 0;
    enable = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == 11) enable = 1'b0;
      if (k == 13) begin
        checks++; if (out_valid !== 1'b1 || left_audio !== 32'hA0 || right_audio !== 32'hB0) begin
          errors++; $display("FAIL en_pair_held: got v=%b L=%h R=%h want 1 a0 b0", out_valid, left_audio, right_audio);
        end
        out_ready = 1'b1;
      end
      if (k == 14) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL en_delivered: got %b want 0", out_valid); end
        push(32'hA1, 32'hB1);
      end
      if (k >= 14 && (out_valid || left_rd_en || right_rd_en)) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL en_idle: got %0d active cycles want 0", extra); end
    checks++; if (nl - s_nl != 1 || mcnt !== 16'd0 || ucnt !== 16'd0) begin
      errors++; $display("FAIL en_counts: got reads=%0d m=%0d u=%0d want 1 0 0", nl - s_nl, mcnt, ucnt);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; en1 = 1'b0; out_ready = 1'b0;
    l1_dout = '0; r1_dout = '0; l1_empty = 1'b1; r1_empty = 1'b1;
    test_reset();
    test_normal();
    test_underrun();
    test_hold();
    test_backpressure();
    test_reset_capture();
    test_enable_present();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/audio_out_sched.md
# audio_out_sched

Stereo output scheduler at the tail of the FM receiver pipeline. Drains the left and right audio FIFOs in lockstep at a fixed audio sample rate derived from `clock`, so the two channels can never drift out of alignment. Presents each stereo sample pair to the downstream DAC/serializer over a valid/ready handshake. Detects and counts underruns and missed sample ticks.

## Interface
- `DATA_WIDTH`, 32, width of each audio sample.
- `TICK_DIV`, 2083, number of `clock` cycles per audio sample period; must be ≥ 4.
- `HOLD_ON_UNDERRUN`, 0: 0 = emit zeros on underrun; 1 = repeat the last sample pair.
- `CNT_WIDTH`, 16, width of the status counters.

Ports:
- `clock` in 1, single clock for the whole block.
- `reset` in 1, synchronous, active-high.
- `enable` in 1, run/stop control for scheduling.
- `left_dout` in DATA_WIDTH, data from the left FIFO; valid 1 cycle after `left_rd_en`.
- `left_empty` in 1, left FIFO empty flag.
- `left_rd_en` out 1, left FIFO read strobe.
- `right_dout` in DATA_WIDTH, data from the right FIFO; same read latency as left.
- `right_empty` in 1, right FIFO empty flag.
- `right_rd_en` out 1, right FIFO read strobe.
- `left_audio` out DATA_WIDTH, presented left sample.
- `right_audio` out DATA_WIDTH, presented right sample.
- `out_valid` out 1, sample pair is valid.
- `out_ready` in 1, downstream accepts the pair.
- `underrun_count` out CNT_WIDTH, number of ticks with either FIFO empty; saturating.
- `missed_tick_count` out CNT_WIDTH, number of ticks lost while a pair was still waiting; saturating.

## Operation
- The tick generator counts 0..TICK_DIV-1. It pulses `tick` for one cycle when the count equals TICK_DIV-1, then wraps to 0. It runs only while `enable`=1 and is held at 0 otherwise.
- FSM states and transitions:
  - IDLE: go to WAIT when `enable`=1.
  - WAIT:
    - `enable`=0: go to IDLE.
    - `tick` with both FIFOs non-empty: go to FETCH.
    - `tick` with either FIFO empty: underrun path, go to PRESENT.
  - FETCH: assert `left_rd_en` and `right_rd_en` together for exactly 1 cycle; go to CAPTURE.
  - CAPTURE: register `left_dout` and `right_dout`; go to PRESENT.
  - PRESENT: hold `out_valid`=1 with stable data until `out_ready`=1. On that handshake go to WAIT, or to IDLE if `enable`=0.
- The read strobes never assert individually. If only one FIFO is non-empty at a tick, it counts as an underrun and neither FIFO is read, which preserves L/R alignment.
- Underrun path data:
  - HOLD_ON_UNDERRUN=0: output 0/0.
  - HOLD_ON_UNDERRUN=1: output the last captured pair (0/0 if no pair has been captured since reset).
  - `underrun_count` increments by 1.
- A `tick` in PRESENT, when not accepted in that same cycle, increments `missed_tick_count` and is discarded. A `tick` coinciding with the handshake cycle is also counted missed.
- `enable` deasserted mid-sequence: FETCH, CAPTURE and PRESENT always complete. No FIFO read is ever abandoned.
- Both counters saturate at all-ones.

## Timing
- All outputs are reset to 0 and the FSM goes to IDLE.
- Tick counter and both status counters are cleared by reset.
- Reset mid-operation aborts immediately. Any pair already read from the FIFOs is dropped, and `out_valid` is 0 on the next cycle.
- Normal path, `tick` high in WAIT at cycle t:
  - `*_rd_en`=1 in cycle t+1.
  - FIFO data is latched at the end of t+2.
  - `out_valid`=1 from cycle t+3.
- Underrun path: `out_valid`=1 from cycle t+1; `underrun_count` updates at t+1.
- Handshake completes on the rising edge where `out_valid`=1 and `out_ready`=1. `out_valid` drops in the next cycle unless a new pair is already scheduled; back-to-back pairs require a new tick.
- `left_audio` and `right_audio` are registered and change only on capture or underrun entry.
- Throughput: at most one pair per TICK_DIV cycles.

## Structure
- The shared package `audio_out_pkg` holds:
  - the FSM state enum (IDLE, WAIT, FETCH, CAPTURE, PRESENT);
  - the default TICK_DIV constant;
  - the underrun mode constants.
- One sub-module, `sample_tick_gen`: a parameterized TICK_DIV divider with an `enable` input and a one-cycle `tick` output.
- The FSM, capture registers and counters live in `audio_out_sched`.

## Test plan
- Both FIFOs hold 3 pairs (L=0x10,0x11,0x12 / R=0x20,0x21,0x22), TICK_DIV=8, `out_ready`=1:
  - exactly 3 pairs presented, in order, 8 cycles apart;
  - each read strobe pulses 3 times, simultaneously;
  - `out_valid` appears 3 cycles after each tick.
- Left holds 1 sample, right is empty, at a tick, HOLD_ON_UNDERRUN=0:
  - outputs 0/0;
  - `underrun_count`=1;
  - no `rd_en` pulse on either FIFO.
- HOLD_ON_UNDERRUN=1: after pair 0x5/0x6 is presented, both FIFOs empty at the next tick → re-presents 0x5/0x6 and `underrun_count` increments.
- `out_ready` held low for 20 cycles with TICK_DIV=8:
  - pair stays stable;
  - `missed_tick_count`=2 (or 3 if a tick hits the handshake cycle);
  - no extra FIFO reads.
- Assert `reset` in CAPTURE: next cycle `out_valid`=0 and counters are 0. After release with `enable`=1, the first tick resumes normal operation.
- Deassert `enable` while in PRESENT: the pair is still delivered on `out_ready`, the FSM then goes to IDLE, and no further ticks or reads occur.
